// File: rtl/tt_bin_clock_pkg.sv
// tt_bin_clock_pkg: shared state encoding and default timing for the binary clock front panel.
package tt_bin_clock_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_e;
  localparam int DEF_DEB_CYCLES    = 4;
  localparam int DEF_REPEAT_DELAY  = 50;
  localparam int DEF_REPEAT_PERIOD = 20;
  localparam int DEF_IDLE_TIMEOUT  = 1000;
  // Mode walks the fields in encoding order and wraps SET_SEC back to RUN.
  function automatic state_e next_field(input state_e s);
    return state_e'(s + 2'd1);
  endfunction
endpackage

// File: rtl/tt_btn_debounce.sv
// tt_btn_debounce: 2-FF synchroniser plus counter debounce with a one-cycle press event.
module tt_btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic r_s1, r_s2, r_deb, r_press;
  logic [CW-1:0] r_cnt;
  logic w_flip;
  assign w_flip = (r_s2 != r_deb) && (r_cnt == LAST);
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_deb   <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= btn_i;
      r_s2    <= r_s1;
      r_cnt   <= (r_s2 == r_deb || w_flip) ? '0 : r_cnt + 1'b1;
      r_deb   <= w_flip ? r_s2 : r_deb;
      r_press <= w_flip & r_s2;
    end
  end
  assign level_o = r_deb;
  assign press_o = r_press;
endmodule

// File: rtl/tt_bin_clock_set_ctrl.sv
// tt_bin_clock_set_ctrl: front-panel field-select FSM with debounced buttons and hold-to-repeat stepping.
module tt_bin_clock_set_ctrl
  import tt_bin_clock_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int IDLE_TIMEOUT  = DEF_IDLE_TIMEOUT
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_mode_i,
  input  logic btn_up_i,
  input  logic btn_down_i,
  output logic time_set_o,
  output logic hour_sel_o,
  output logic minute_sel_o,
  output logic seconds_sel_o,
  output logic step_o,
  output logic dir_o
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PER = RW'(REPEAT_PERIOD - 1);
  localparam logic [IW-1:0] I_MAX = IW'(IDLE_TIMEOUT);
  logic w_mode, w_up, w_dn, w_mode_p, w_up_p, w_dn_p;
  tt_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clk_i(clk_i), .reset_ni(reset_ni), .btn_i(btn_mode_i), .level_o(w_mode), .press_o(w_mode_p));
  tt_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk_i(clk_i), .reset_ni(reset_ni), .btn_i(btn_up_i), .level_o(w_up), .press_o(w_up_p));
  tt_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
    .clk_i(clk_i), .reset_ni(reset_ni), .btn_i(btn_down_i), .level_o(w_dn), .press_o(w_dn_p));
  state_e r_state;
  logic r_time_set, r_hr, r_min, r_sec, r_step, r_dir;
  logic r_blk_up, r_blk_dn, r_h, r_first;
  logic [RW-1:0] r_rep;
  logic [IW-1:0] r_idle;
  logic w_set, w_tout, w_stop, w_h, w_step, w_busy;
  state_e w_nxt;
  assign w_set  = r_state != RUN;
  assign w_tout = w_set && r_idle == I_MAX;
  assign w_stop = w_mode_p | w_tout;
  assign w_nxt  = w_mode_p ? next_field(r_state) : (w_tout ? RUN : r_state);
  // A button that was down in RUN or across a mode press stays blocked until released.
  assign w_h    = w_set & (w_up ^ w_dn) & ~(w_up ? r_blk_up : r_blk_dn) & ~w_stop;
  assign w_step = w_h & (~r_h | r_rep == (r_first ? R_DLY : R_PER));
  assign w_busy = w_up_p | w_dn_p | w_mode_p | w_mode | (w_up & ~r_blk_up) | (w_dn & ~r_blk_dn);
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= RUN;
      r_time_set <= 1'b0;
      r_hr       <= 1'b0;
      r_min      <= 1'b0;
      r_sec      <= 1'b0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_blk_up   <= 1'b0;
      r_blk_dn   <= 1'b0;
      r_h        <= 1'b0;
      r_first    <= 1'b1;
      r_rep      <= '0;
      r_idle     <= '0;
    end else begin
      r_state    <= w_nxt;
      r_time_set <= w_nxt != RUN;
      r_hr       <= w_nxt == SET_HR;
      r_min      <= w_nxt == SET_MIN;
      r_sec      <= w_nxt == SET_SEC;
      r_idle     <= (w_nxt == RUN || w_busy) ? '0 : (r_idle == I_MAX ? r_idle : r_idle + 1'b1);
      r_blk_up   <= w_up & (r_blk_up | ~w_set | w_stop);
      r_blk_dn   <= w_dn & (r_blk_dn | ~w_set | w_stop);
      r_h        <= w_h;
      r_rep      <= (!w_h || w_step) ? '0 : r_rep + 1'b1;
      r_first    <= (!w_h || !r_h) ? 1'b1 : (w_step ? 1'b0 : r_first);
      r_step     <= w_step;
      r_dir      <= w_step ? w_up : r_dir;
    end
  end
  assign time_set_o    = r_time_set;
  assign hour_sel_o    = r_hr;
  assign minute_sel_o  = r_min;
  assign seconds_sel_o = r_sec;
  assign step_o        = r_step;
  assign dir_o         = r_dir;
endmodule
